// File: rtl/ahb_bm_input_stage.sv
// ahb_bm_input_stage: master-facing input stage of the AHB bus matrix; holds and replays a losing address phase.
// Optional HAUSER capture/forwarding is enabled by defining AHB_BM_USER_EN (default build ties auser_ip to 0).
module ahb_bm_input_stage #(
   parameter int ADDR_WIDTH = 32,
   parameter int USER_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSELS,
   input  logic [ADDR_WIDTH-1:0] HADDRS,
   input  logic [USER_WIDTH-1:0] HAUSERS,
   input  logic [1:0]            HTRANSS,
   input  logic                  HWRITES,
   input  logic [2:0]            HSIZES,
   input  logic [2:0]            HBURSTS,
   input  logic [3:0]            HPROTS,
   input  logic [3:0]            HMASTERS,
   input  logic                  HMASTLOCKS,
   input  logic                  HREADYS,
   input  logic                  active_ip,
   input  logic                  readyout_ip,
   input  logic [1:0]            resp_ip,
   output logic                  sel_ip,
   output logic [ADDR_WIDTH-1:0] addr_ip,
   output logic [USER_WIDTH-1:0] auser_ip,
   output logic [1:0]            trans_ip,
   output logic                  write_ip,
   output logic [2:0]            size_ip,
   output logic [2:0]            burst_ip,
   output logic [3:0]            prot_ip,
   output logic [3:0]            master_ip,
   output logic                  mastlock_ip,
   output logic                  held_tran_ip,
   output logic                  HREADYOUTS,
   output logic [1:0]            HRESPS,
   output logic [1:0]            dbg_state    // 0 IDLE, 1 WAIT, 2 DATA
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   typedef struct packed {
      logic                  sel;
      logic [ADDR_WIDTH-1:0] addr;
      logic [1:0]            trans;
      logic                  write;
      logic [2:0]            size;
      logic [2:0]            burst;
      logic [3:0]            prot;
      logic [3:0]            master;
      logic                  mastlock;
   } ctrl_t;

   state_e state_q, state_d;
   logic   pend_q, pend_d;
   ctrl_t  hold_q, hold_d;
   ctrl_t  live, cur;
   logic   trans_valid, accept, load;

   // Handshake: held_tran_ip is the request; a request is consumed in the
   // cycle where active_ip and readyout_ip are both high alongside it.
   assign trans_valid  = HSELS & HTRANSS[1] & HREADYS;
   assign held_tran_ip = pend_q | trans_valid;
   assign accept       = held_tran_ip & active_ip & readyout_ip;
   assign load         = trans_valid & ~accept & ~pend_q;

   always_comb begin
      live.sel      = HSELS;
      live.addr     = HADDRS;
      live.trans    = HTRANSS;
      live.write    = HWRITES;
      live.size     = HSIZES;
      live.burst    = HBURSTS;
      live.prot     = HPROTS;
      live.master   = HMASTERS;
      live.mastlock = HMASTLOCKS;
   end

   assign hold_d = load ? live : hold_q;
   assign pend_d = accept ? 1'b0 : (load ? 1'b1 : pend_q);
   assign cur    = pend_q ? hold_q : live;

   assign sel_ip      = cur.sel;
   assign addr_ip     = cur.addr;
   assign trans_ip    = cur.trans;
   assign write_ip    = cur.write;
   assign size_ip     = cur.size;
   assign burst_ip    = cur.burst;
   assign prot_ip     = cur.prot;
   assign master_ip   = cur.master;
   assign mastlock_ip = cur.mastlock;
   assign dbg_state   = state_q;

`ifdef AHB_BM_USER_EN
   logic [USER_WIDTH-1:0] hold_auser_q, hold_auser_d;

   assign hold_auser_d = load ? HAUSERS : hold_auser_q;
   assign auser_ip     = pend_q ? hold_auser_q : HAUSERS;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) hold_auser_q <= '0;
      else          hold_auser_q <= hold_auser_d;
   end
`else
   logic unused_hausers;

   assign unused_hausers = ^HAUSERS;
   assign auser_ip       = '0;
`endif

   always_comb begin
      state_d    = state_q;
      HREADYOUTS = 1'b1;
      HRESPS     = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (trans_valid) state_d = accept ? ST_DATA : ST_WAIT;
         end
         ST_WAIT: begin
            HREADYOUTS = 1'b0;
            if (accept) state_d = ST_DATA;
         end
         ST_DATA: begin
            // Slave owns the response; the next address phase is only sampled when it completes.
            HREADYOUTS = readyout_ip;
            HRESPS     = resp_ip;
            if (readyout_ip) begin
               if (trans_valid) state_d = accept ? ST_DATA : ST_WAIT;
               else             state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         pend_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// tb_ahb_bm_input_stage: directed plus random checks of ahb_bm_input_stage against a transfer-level model.
// HREADYS is looped back from HREADYOUTS as a single master would see it.
module tb_ahb_bm_input_stage;
   localparam int AW = 32;
   localparam int UW = 32;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          HSELS = 1'b0;
   logic [AW-1:0] HADDRS = '0;
   logic [UW-1:0] HAUSERS = '0;
   logic [1:0]    HTRANSS = 2'b00;
   logic          HWRITES = 1'b0;
   logic [2:0]    HSIZES = '0;
   logic [2:0]    HBURSTS = '0;
   logic [3:0]    HPROTS = '0;
   logic [3:0]    HMASTERS = '0;
   logic          HMASTLOCKS = 1'b0;
   logic          HREADYS;
   logic          active_ip = 1'b0;
   logic          readyout_ip = 1'b1;
   logic [1:0]    resp_ip = 2'b00;
   logic          sel_ip, write_ip, mastlock_ip, held_tran_ip, HREADYOUTS;
   logic [AW-1:0] addr_ip;
   logic [UW-1:0] auser_ip;
   logic [1:0]    trans_ip, HRESPS, dbg_state;
   logic [2:0]    size_ip, burst_ip;
   logic [3:0]    prot_ip, master_ip;

   always #5 HCLK = ~HCLK;
   assign HREADYS = HREADYOUTS;

   ahb_bm_input_stage #(.ADDR_WIDTH(AW), .USER_WIDTH(UW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HAUSERS(HAUSERS),
      .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
      .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .active_ip(active_ip),
      .readyout_ip(readyout_ip), .resp_ip(resp_ip), .sel_ip(sel_ip), .addr_ip(addr_ip),
      .auser_ip(auser_ip), .trans_ip(trans_ip), .write_ip(write_ip), .size_ip(size_ip),
      .burst_ip(burst_ip), .prot_ip(prot_ip), .master_ip(master_ip), .mastlock_ip(mastlock_ip),
      .held_tran_ip(held_tran_ip), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .dbg_state(dbg_state)
   );

   typedef struct {
      logic          sel;
      logic [AW-1:0] addr;
      logic [UW-1:0] auser;
      logic [1:0]    trans;
      logic          write;
      logic [2:0]    size;
      logic [2:0]    burst;
      logic [3:0]    prot;
      logic [3:0]    master;
      logic          mastlock;
   } xfer_t;

   // Model: queue of address phases waiting for a grant, and whether a granted transfer is in its data phase.
   xfer_t held_q[$];
   bit    in_data = 1'b0;
   logic  m_ready, m_held, m_live_valid;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic xfer_t live_bus();
      xfer_t x;
      x.sel = HSELS; x.addr = HADDRS; x.auser = HAUSERS; x.trans = HTRANSS; x.write = HWRITES;
      x.size = HSIZES; x.burst = HBURSTS; x.prot = HPROTS; x.master = HMASTERS; x.mastlock = HMASTLOCKS;
      return x;
   endfunction

   task automatic model_reset();
      held_q.delete();
      in_data = 1'b0;
   endtask

   task automatic cycle_check();
      xfer_t         e;
      bit            waiting;
      logic [1:0]    exp_resp, exp_state;
      logic [UW-1:0] exp_auser;
      #1;
      waiting      = (held_q.size() != 0);
      e            = waiting ? held_q[0] : live_bus();
      m_ready      = waiting ? 1'b0 : (in_data ? readyout_ip : 1'b1);
      exp_resp     = (!waiting && in_data) ? resp_ip : 2'b00;
      m_live_valid = HSELS & HTRANSS[1] & m_ready;
      m_held       = waiting | m_live_valid;
      exp_state    = waiting ? 2'd1 : (in_data ? 2'd2 : 2'd0);
`ifdef AHB_BM_USER_EN
      exp_auser = e.auser;
`else
      exp_auser = '0;
`endif
      check("hreadyouts", HREADYOUTS, m_ready);
      check("hresps", HRESPS, exp_resp);
      check("held_tran", held_tran_ip, m_held);
      check("state", dbg_state, exp_state);
      check("sel_ip", sel_ip, e.sel);
      check("addr_ip", addr_ip, e.addr);
      check("auser_ip", auser_ip, exp_auser);
      check("trans_ip", trans_ip, e.trans);
      check("write_ip", write_ip, e.write);
      check("ctrl_ip", {size_ip, burst_ip, prot_ip, master_ip, mastlock_ip},
            {e.size, e.burst, e.prot, e.master, e.mastlock});
   endtask

   task automatic cycle_end();
      bit granted;
      granted = m_held & active_ip & readyout_ip;
      if (held_q.size() != 0) begin
         if (granted) begin
            void'(held_q.pop_front());
            in_data = 1'b1;
         end
      end else if (m_ready) begin
         if (m_live_valid) begin
            if (granted) in_data = 1'b1;
            else begin
               held_q.push_back(live_bus());
               in_data = 1'b0;
            end
         end else begin
            in_data = 1'b0;
         end
      end
      @(negedge HCLK);
   endtask

   task automatic step();
      cycle_check();
      cycle_end();
   endtask

   task automatic drive_addr(input logic [1:0] tr, input logic wr, input logic [AW-1:0] a);
      HSELS = 1'b1; HTRANSS = tr; HWRITES = wr; HADDRS = a; HAUSERS = $urandom;
      HSIZES = 3'($urandom_range(0, 2)); HBURSTS = 3'($urandom_range(0, 7));
      HPROTS = 4'($urandom); HMASTERS = 4'($urandom); HMASTLOCKS = 1'($urandom_range(0, 1));
   endtask

   task automatic set_slave(input logic act, input logic rdy, input logic [1:0] rsp);
      active_ip = act; readyout_ip = rdy; resp_ip = rsp;
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_ready", HREADYOUTS, 1'b1);
      check("rst_resp", HRESPS, 2'b00);
      check("rst_held", held_tran_ip, 1'b0);
      check("rst_state", dbg_state, 2'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      model_reset();

      // Idle bus
      drive_addr(2'b00, 1'b0, 32'h0000_0100);
      set_slave(1'b1, 1'b1, 2'b00);
      step();
      step();

      // Immediate grant, then two slave wait states
      drive_addr(2'b10, 1'b1, 32'h2000_0010);
      cycle_check();
      check("grant_addr", addr_ip, 32'h2000_0010);
      cycle_end();
      drive_addr(2'b00, 1'b0, 32'h0);
      set_slave(1'b1, 1'b0, 2'b00);
      cycle_check();
      check("dwait1", HREADYOUTS, 1'b0);
      cycle_end();
      cycle_check();
      check("dwait2", HREADYOUTS, 1'b0);
      cycle_end();
      set_slave(1'b1, 1'b1, 2'b00);
      cycle_check();
      check("dwait_done", HREADYOUTS, 1'b1);
      cycle_end();

      // Lost arbitration, address changes on the live bus while held
      drive_addr(2'b10, 1'b0, 32'h4000_0000);
      set_slave(1'b0, 1'b1, 2'b00);
      step();
      HADDRS = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         cycle_check();
         check("hold_addr", addr_ip, 32'h4000_0000);
         check("hold_ready", HREADYOUTS, 1'b0);
         check("hold_req", held_tran_ip, 1'b1);
         cycle_end();
      end
      set_slave(1'b1, 1'b1, 2'b00);
      step();
      HTRANSS = 2'b00;
      cycle_check();
      check("after_grant_state", dbg_state, 2'd2);
      cycle_end();

      // Back-to-back: data phase completes while next address loses arbitration
      drive_addr(2'b10, 1'b1, 32'h1000_0040);
      step();
      drive_addr(2'b10, 1'b0, 32'h1000_0080);
      set_slave(1'b0, 1'b1, 2'b00);
      step();
      HADDRS = 32'h5555_0000;
      cycle_check();
      check("b2b_capture", addr_ip, 32'h1000_0080);
      cycle_end();
      set_slave(1'b1, 1'b1, 2'b00);
      step();
      HTRANSS = 2'b00;
      cycle_check();
      check("b2b_no_reissue", held_tran_ip, 1'b0);
      cycle_end();

      // Two-cycle ERROR response forwarded
      drive_addr(2'b10, 1'b1, 32'h3000_0000);
      step();
      HTRANSS = 2'b00;
      set_slave(1'b1, 1'b0, 2'b01);
      cycle_check();
      check("err1_resp", HRESPS, 2'b01);
      check("err1_ready", HREADYOUTS, 1'b0);
      cycle_end();
      set_slave(1'b1, 1'b1, 2'b01);
      cycle_check();
      check("err2_resp", HRESPS, 2'b01);
      check("err2_ready", HREADYOUTS, 1'b1);
      cycle_end();
      set_slave(1'b1, 1'b1, 2'b00);

      // Reset while holding a transfer
      drive_addr(2'b10, 1'b0, 32'h6000_0000);
      set_slave(1'b0, 1'b1, 2'b00);
      step();
      step();
      HRESETn = 1'b0;
      HSELS = 1'b0; HTRANSS = 2'b00; HADDRS = 32'h1234_5678;
      #1;
      check("rstw_ready", HREADYOUTS, 1'b1);
      check("rstw_held", held_tran_ip, 1'b0);
      check("rstw_addr", addr_ip, 32'h1234_5678);
      check("rstw_state", dbg_state, 2'd0);
      model_reset();
      @(negedge HCLK);
      HRESETn = 1'b1;
      step();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive_addr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
         HSELS = ($urandom_range(0, 3) != 0);
         set_slave($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ahb_bm_input_stage.md
Name: ahb_bm_input_stage

Overview:
- Master-facing input stage of the AHB bus matrix.
- Sits between one AHB master port and the per-slave output stages. It is the upstream producer of the sel/addr/trans/.../held_tran signals that output stages arbitrate on.
- Captures an address phase that loses arbitration and replays it until granted.
- Generates HREADYOUTS/HRESPS back to the master: waits while held, mirrors the slave during the data phase.

Parameters:
- ADDR_WIDTH, 32, address and held-address register width
- USER_WIDTH, 32, HAUSER width

Ports:
- HCLK  input  1  AHB clock
- HRESETn  input  1  async active-low reset
- HSELS  input  1  master-side select
- HADDRS  input  ADDR_WIDTH  address
- HAUSERS  input  USER_WIDTH  user address bus
- HTRANSS  input  2  transfer type
- HWRITES  input  1  direction
- HSIZES  input  3  size
- HBURSTS  input  3  burst
- HPROTS  input  4  protection
- HMASTERS  input  4  master ID
- HMASTLOCKS  input  1  lock
- HREADYS  input  1  HREADY seen by master (address sample qualifier)
- active_ip  input  1  OR of output stages' active signals for this port
- readyout_ip  input  1  HREADYMUX of the output stage owning this port's data phase
- resp_ip  input  2  HRESP of that output stage
- sel_ip, addr_ip, auser_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip, master_ip, mastlock_ip  output  (widths as inputs)  address/control toward output stages
- held_tran_ip  output  1  valid transfer request toward output stages
- HREADYOUTS  output  1  ready to master
- HRESPS  output  2  response to master

Behaviour:
- Reset and clocking: HRESETn asynchronous, active-low; clock HCLK.
- Reset values: state IDLE; hold registers 0; pend=0; HREADYOUTS=1; HRESPS=OKAY(2'b00); held_tran_ip=0.
- Definitions:
  - trans_valid = HSELS & HTRANSS[1] & HREADYS.
  - accept = held_tran_ip & active_ip & readyout_ip.
- Output mux:
  - pend=1: all *_ip outputs come from the hold registers.
  - pend=0: all *_ip outputs come from the live master bus.
  - held_tran_ip = pend | trans_valid.
- Hold registers load all address/control fields when trans_valid & ~accept; pend set.
- pend clears on accept.
- Hold registers never load while pend=1. HREADYOUTS=0 then, so HREADYS=0 at the master.
- States:
  - IDLE: HREADYOUTS=1, HRESPS=OKAY. trans_valid&accept -> DATA; trans_valid&~accept -> WAIT; else stay.
  - WAIT: HREADYOUTS=0, HRESPS=OKAY. accept -> DATA; else stay.
  - DATA: HREADYOUTS=readyout_ip, HRESPS=resp_ip.
    - readyout_ip=0: stay.
    - readyout_ip=1 and new trans_valid&accept: stay DATA.
    - readyout_ip=1 and trans_valid&~accept: WAIT, with capture.
    - readyout_ip=1 and no trans_valid: IDLE.
- IDLE/BUSY transfers with HSELS=1:
  - Passed through on *_ip with held_tran_ip=0.
  - In IDLE: zero-wait OKAY.
  - In DATA: HREADYOUTS still follows the slave.
- ERROR response (two-cycle) is forwarded unchanged from resp_ip/readyout_ip.
  - A held transfer is still replayed after an ERROR. Master cancellation applies only to unheld transfers.
- Latency:
  - Granted in the same cycle: zero added latency.
  - Lost arbitration: one extra wait per cycle held.
- Reset mid-WAIT/DATA: immediate return to IDLE, pend=0, HREADYOUTS=1.

Optional Feature:
- Macro: AHB_BM_USER_EN.
- Defined: HAUSERS is captured in the hold register and forwarded on auser_ip.
- Undefined: no HAUSER hold register; auser_ip is tied to 0; HAUSERS is ignored.

Test Plan:
- Idle bus: HSELS=1, HTRANSS=IDLE -> HREADYOUTS=1, HRESPS=0, held_tran_ip=0, state stays IDLE.
- Immediate grant: NONSEQ write to 0x2000_0010, active_ip=1, readyout_ip=1.
  - addr_ip=0x2000_0010 same cycle.
  - Next cycle DATA; readyout_ip=0 for 2 cycles -> HREADYOUTS=0 for exactly those 2 cycles.
- Lost arbitration: NONSEQ read 0x4000_0000 with active_ip=0 for 3 cycles.
  - HREADYOUTS=0 for 3 cycles.
  - addr_ip holds 0x4000_0000 while HADDRS changes to 0xFFFF_FFFF.
  - held_tran_ip=1 throughout; grant -> DATA next cycle.
- Back-to-back: DATA completes (readyout_ip=1) while a new NONSEQ is presented with active_ip=0.
  - -> WAIT, capture correct.
  - No double issue: held_tran_ip de-asserts after accept.
- Error: resp_ip=ERROR with readyout_ip 0 then 1 -> HRESPS=2'b01 on both cycles, HREADYOUTS=0 then 1.
- Reset in WAIT: assert HRESETn=0 mid-hold -> HREADYOUTS=1, held_tran_ip=0 asynchronously; addr_ip reverts to live bus.
